// File: rtl/snake_world_ctrl_if.sv
// World-memory port bundle: the controller's write port plus the shared read-address path.
interface snake_world_ctrl_if;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       rd_sel;
    logic [1:0] rd_data;
    logic [3:0] mem_x;
    logic [3:0] mem_y;
    logic [1:0] mem_data;
    logic       mem_we;

    modport master (output rd_x, rd_y, rd_sel, mem_x, mem_y, mem_data, mem_we, input rd_data);
    modport slave  (input rd_x, rd_y, rd_sel, mem_x, mem_y, mem_data, mem_we, output rd_data);
endinterface

// File: rtl/snake_world_ctrl.sv
// Snake game sequencer: sole writer of the 15x15 world memory, reads only during VGA blanking.
// Optional SNAKE_WRAP_EN: the head wraps to the opposite edge instead of ending the game.
module snake_world_ctrl #(
    parameter int         GRID      = 15,
    parameter int         MAX_LEN   = 32,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step_tick,
    input  logic [1:0]         dir_in,
    input  logic               vga_blank,
    snake_world_ctrl_if.master mem,
    output logic [5:0]         length,
    output logic               busy,
    output logic               game_over
);
    localparam int PW = $clog2(MAX_LEN);
    localparam logic [3:0] G4 = 4'(GRID);
    localparam logic [4:0] G5 = 5'(GRID);

    localparam logic [2:0] S_CLEAR   = 3'd0, S_INIT    = 3'd1, S_IDLE = 3'd2, S_RD_HEAD = 3'd3,
                           S_WR_HEAD = 3'd4, S_ER_TAIL = 3'd5, S_FOOD = 3'd6, S_OVER    = 3'd7;
    localparam logic [1:0] C_WORLD = 2'b00, C_FOOD = 2'b01, C_SNAKE = 2'b10;
    localparam logic [1:0] D_UP = 2'b00, D_RIGHT = 2'b01, D_DOWN = 2'b10, D_LEFT = 2'b11;

    logic [2:0]    state;
    logic [7:0]    lfsr;
    logic [1:0]    dir, dir_next;
    logic          pending, grow;
    logic [3:0]    cx, cy;
    logic [4:0]    nx, ny, step_x, step_y;
    logic [7:0]    tries;
    logic [PW-1:0] head_ptr, tail_ptr;
    logic [7:0]    queue [MAX_LEN];
    logic [7:0]    head_cell, tail_cell;
    logic [3:0]    fx, fy;
    logic          in_range, rd_own, at_tail, will_grow;

    assign head_cell = queue[head_ptr];
    assign tail_cell = queue[tail_ptr];
    assign busy      = (state != S_IDLE) && (state != S_OVER);
    assign fx        = (lfsr[3:0] % G4) + 4'd1;
    assign fy        = (lfsr[7:4] % G4) + 4'd1;
    assign in_range  = (nx != 5'd0) && (nx <= G5) && (ny != 5'd0) && (ny <= G5);
    assign at_tail   = (tail_cell == {nx[3:0], ny[3:0]});
    assign will_grow = grow && (length < 6'(MAX_LEN));

    // Next head from the latched direction; a request to reverse onto the body is ignored.
    always_comb begin
        dir_next = ((dir_in ^ dir) == 2'b10) ? dir : dir_in;
        step_x   = {1'b0, head_cell[7:4]};
        step_y   = {1'b0, head_cell[3:0]};
        case (dir_next)
            D_UP:    step_y = step_y - 5'd1;
            D_RIGHT: step_x = step_x + 5'd1;
            D_DOWN:  step_y = step_y + 5'd1;
            default: step_x = step_x - 5'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (step_x == 5'd0) step_x = G5;
        else if (step_x == G5 + 5'd1) step_x = 5'd1;
        if (step_y == 5'd0) step_y = G5;
        else if (step_y == G5 + 5'd1) step_y = 5'd1;
`endif
    end

    // Read path is combinational so rd_data belongs to the same blanking cycle that sampled it.
    always_comb begin
        rd_own     = (((state == S_RD_HEAD) && in_range) || (state == S_FOOD)) && vga_blank;
        mem.rd_sel = rd_own;
        mem.rd_x   = 4'd1;
        mem.rd_y   = 4'd1;
        if (rd_own) begin
            if (state == S_FOOD) begin
                mem.rd_x = fx;
                mem.rd_y = fy;
            end else begin
                mem.rd_x = nx[3:0];
                mem.rd_y = ny[3:0];
            end
        end
    end

    // NOTE: queue has no reset; every entry is written before the head/tail pointers reach it.
    always_ff @(posedge clk) begin
        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        mem.mem_we <= 1'b0;
        if (!rst || start) begin
            if (!rst) lfsr <= LFSR_SEED;
            state        <= S_CLEAR;
            mem.mem_x    <= 4'd1;
            mem.mem_y    <= 4'd1;
            mem.mem_data <= C_WORLD;
            game_over    <= 1'b0;
            length       <= 6'(INIT_LEN);
            dir          <= D_RIGHT;
            pending      <= 1'b0;
            grow         <= 1'b0;
            cx           <= 4'd1;
            cy           <= 4'd1;
            nx           <= 5'd1;
            ny           <= 5'd1;
            tries        <= 8'd0;
            head_ptr     <= '0;
            tail_ptr     <= '0;
        end else begin
            if (step_tick && busy) pending <= 1'b1;
            case (state)
                S_CLEAR: begin
                    mem.mem_we   <= 1'b1;
                    mem.mem_x    <= cx;
                    mem.mem_y    <= cy;
                    mem.mem_data <= C_WORLD;
                    if (cx == G4) begin
                        cx <= 4'd1;
                        if (cy == G4) begin
                            cy    <= 4'd1;
                            state <= S_INIT;
                        end else begin
                            cy <= cy + 4'd1;
                        end
                    end else begin
                        cx <= cx + 4'd1;
                    end
                end
                S_INIT: begin
                    mem.mem_we <= 1'b1;
                    if (cx <= 4'(INIT_LEN)) begin
                        mem.mem_x            <= cx;
                        mem.mem_y            <= 4'd1;
                        mem.mem_data         <= C_SNAKE;
                        queue[PW'(cx - 4'd1)] <= {cx, 4'd1};
                        cx                   <= cx + 4'd1;
                    end else begin
                        mem.mem_x    <= 4'd11;
                        mem.mem_y    <= 4'd4;
                        mem.mem_data <= C_FOOD;
                        head_ptr     <= PW'(INIT_LEN - 1);
                        tail_ptr     <= '0;
                        state        <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (step_tick || pending) begin
                        pending <= 1'b0;
                        dir     <= dir_next;
                        nx      <= step_x;
                        ny      <= step_y;
                        state   <= S_RD_HEAD;
                    end
                end
                S_RD_HEAD: begin
                    if (!in_range) begin
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else if (vga_blank) begin
                        if (mem.rd_data == C_SNAKE && !at_tail) begin
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            grow         <= (mem.rd_data == C_FOOD);
                            mem.mem_we   <= 1'b1;
                            mem.mem_x    <= nx[3:0];
                            mem.mem_y    <= ny[3:0];
                            mem.mem_data <= C_SNAKE;
                            state        <= S_WR_HEAD;
                        end
                    end
                end
                S_WR_HEAD: begin
                    // Head write is on the bus now; queue the tail erase for the next cycle.
                    queue[head_ptr + PW'(1)] <= {nx[3:0], ny[3:0]};
                    head_ptr                 <= head_ptr + PW'(1);
                    if (!will_grow && !at_tail) begin
                        mem.mem_we   <= 1'b1;
                        mem.mem_x    <= tail_cell[7:4];
                        mem.mem_y    <= tail_cell[3:0];
                        mem.mem_data <= C_WORLD;
                    end
                    state <= S_ER_TAIL;
                end
                S_ER_TAIL: begin
                    if (will_grow) length   <= length + 6'd1;
                    else           tail_ptr <= tail_ptr + PW'(1);
                    tries <= 8'd0;
                    state <= grow ? S_FOOD : S_IDLE;
                end
                S_FOOD: begin
                    if (vga_blank) begin
                        if (mem.rd_data == C_WORLD) begin
                            mem.mem_we   <= 1'b1;
                            mem.mem_x    <= fx;
                            mem.mem_y    <= fy;
                            mem.mem_data <= C_FOOD;
                            state        <= S_IDLE;
                        end else if (tries == 8'd254) begin
                            state <= S_IDLE;
                        end else begin
                            tries <= tries + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_world_ctrl.sv
// Directed bench for snake_world_ctrl: models the world memory and checks write traffic.
`timescale 1ns/1ps
module tb_snake_world_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       step_tick = 1'b0;
    logic [1:0] dir_in = 2'b01;
    logic       vga_blank = 1'b1;
    logic [5:0] length;
    logic       busy;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    snake_world_ctrl_if mif();

    snake_world_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_tick (step_tick),
        .dir_in    (dir_in),
        .vga_blank (vga_blank),
        .mem       (mif),
        .length    (length),
        .busy      (busy),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // World memory model with a log of every write and the value it replaced.
    logic [1:0] world [16][16];
    logic [3:0] log_x [4096];
    logic [3:0] log_y [4096];
    logic [1:0] log_d [4096];
    logic [1:0] log_p [4096];
    int         wr_n = 0;
    logic       poke_en = 1'b0;
    logic [3:0] poke_x = 4'd0;
    logic [3:0] poke_y = 4'd0;
    logic [1:0] poke_d = 2'b00;

    assign mif.rd_data = world[mif.rd_x][mif.rd_y];

    always @(posedge clk) begin
        if (poke_en) world[poke_x][poke_y] <= poke_d;
        if (mif.mem_we === 1'b1) begin
            world[mif.mem_x][mif.mem_y] <= mif.mem_data;
            log_x[wr_n[11:0]] <= mif.mem_x;
            log_y[wr_n[11:0]] <= mif.mem_y;
            log_d[wr_n[11:0]] <= mif.mem_data;
            log_p[wr_n[11:0]] <= world[mif.mem_x][mif.mem_y];
            wr_n <= wr_n + 1;
        end
    end

    task automatic pulse_tick(input logic [1:0] d);
        @(negedge clk);
        dir_in    = d;
        step_tick = 1'b1;
        @(negedge clk);
        step_tick = 1'b0;
    endtask

    task automatic poke(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        @(negedge clk);
        poke_x  = x;
        poke_y  = y;
        poke_d  = d;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, expected 0", tag, busy, budget);
        end
    endtask

    function automatic int count_nonzero();
        int n;
        n = 0;
        for (int x = 1; x <= 15; x++)
            for (int y = 1; y <= 15; y++)
                if (world[x][y] != 2'b00) n++;
        return n;
    endfunction

    task automatic test_reset();
        int base, n00, nz;
        rst = 1'b0;
        vga_blank = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b0, 4'd1, 4'd1, 2'b00}) begin
            errors++;
            $display("FAIL reset_wr_port: got we=%0b x=%0d y=%0d d=%b, expected 0 1 1 00",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        checks++;
        if ({mif.rd_sel, mif.rd_x, mif.rd_y} !== {1'b0, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL reset_rd_port: got sel=%0b x=%0d y=%0d, expected 0 1 1", mif.rd_sel, mif.rd_x, mif.rd_y);
        end
        checks++;
        if ({game_over, length, busy} !== {1'b0, 6'd3, 1'b1}) begin
            errors++;
            $display("FAIL reset_status: got over=%0b len=%0d busy=%0b, expected 0 3 1", game_over, length, busy);
        end
        base = wr_n;
        rst = 1'b1;
        wait_idle("init", 400);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_n - base !== 229) begin
            errors++;
            $display("FAIL init_write_count: got %0d, expected 229", wr_n - base);
        end
        n00 = 0;
        for (int i = 0; i < 225; i++) begin
            int k;
            k = base + i;
            if (log_d[k[11:0]] == 2'b00) n00++;
        end
        checks++;
        if (n00 !== 225) begin
            errors++;
            $display("FAIL clear_zero_writes: got %0d, expected 225", n00);
        end
        checks++;
        if ({log_x[base[11:0]], log_y[base[11:0]], log_x[(base + 224) & 4095], log_y[(base + 224) & 4095]}
            !== {4'd1, 4'd1, 4'd15, 4'd15}) begin
            errors++;
            $display("FAIL clear_order: got first (%0d,%0d) last (%0d,%0d), expected (1,1) (15,15)",
                     log_x[base[11:0]], log_y[base[11:0]],
                     log_x[(base + 224) & 4095], log_y[(base + 224) & 4095]);
        end
        checks++;
        if ({world[1][1], world[2][1], world[3][1], world[11][4]} !== 8'b10_10_10_01) begin
            errors++;
            $display("FAIL init_cells: got %b %b %b food=%b, expected 10 10 10 01",
                     world[1][1], world[2][1], world[3][1], world[11][4]);
        end
        nz = count_nonzero();
        checks++;
        if (nz !== 4 || length !== 6'd3) begin
            errors++;
            $display("FAIL init_world: got nonzero=%0d len=%0d, expected 4 3", nz, length);
        end
    endtask

    task automatic test_step();
        pulse_tick(2'b01);
        checks++;
        if ({mif.mem_we, busy} !== 2'b01) begin
            errors++;
            $display("FAIL step_read_cycle: got we=%0b busy=%0b, expected 0 1", mif.mem_we, busy);
        end
        @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b1, 4'd4, 4'd1, 2'b10}) begin
            errors++;
            $display("FAIL step_head: got we=%0b (%0d,%0d) d=%b, expected 1 (4,1) 10",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b1, 4'd1, 4'd1, 2'b00}) begin
            errors++;
            $display("FAIL step_tail: got we=%0b (%0d,%0d) d=%b, expected 1 (1,1) 00",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        @(negedge clk);
        checks++;
        if ({mif.mem_we, busy, length} !== {1'b0, 1'b0, 6'd3}) begin
            errors++;
            $display("FAIL step_done: got we=%0b busy=%0b len=%0d, expected 0 0 3", mif.mem_we, busy, length);
        end
    endtask

    task automatic test_grow();
        int base, nfood, nzero, fidx;
        poke(4'd5, 4'd1, 2'b01);
        base = wr_n;
        pulse_tick(2'b01);
        @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b1, 4'd5, 4'd1, 2'b10}) begin
            errors++;
            $display("FAIL grow_head: got we=%0b (%0d,%0d) d=%b, expected 1 (5,1) 10",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        @(negedge clk);
        checks++;
        if (mif.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL grow_no_erase: got we=%0b, expected 0", mif.mem_we);
        end
        wait_idle("grow", 600);
        repeat (2) @(negedge clk);
        nfood = 0;
        nzero = 0;
        fidx  = base;
        for (int i = base; i < wr_n; i++) begin
            if (log_d[i[11:0]] == 2'b01) begin
                nfood++;
                fidx = i;
            end
            if (log_d[i[11:0]] == 2'b00) nzero++;
        end
        checks++;
        if ({nfood, nzero} !== {32'd1, 32'd0} || log_p[fidx[11:0]] !== 2'b00) begin
            errors++;
            $display("FAIL grow_food: got food_writes=%0d erases=%0d prev=%b, expected 1 0 00",
                     nfood, nzero, log_p[fidx[11:0]]);
        end
        checks++;
        if (length !== 6'd4) begin
            errors++;
            $display("FAIL grow_length: got %0d, expected 4", length);
        end
        if (nfood == 1) poke(log_x[fidx[11:0]], log_y[fidx[11:0]], 2'b00);
    endtask

    task automatic test_stall();
        int base, bad;
        base = wr_n;
        bad  = 0;
        @(negedge clk);
        vga_blank = 1'b0;
        pulse_tick(2'b01);
        for (int i = 0; i < 50; i++) begin
            if (mif.rd_sel !== 1'b0 || mif.mem_we !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0 || wr_n !== base || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_quiet: got bad_cycles=%0d writes=%0d busy=%0b, expected 0 0 1", bad, wr_n - base, busy);
        end
        vga_blank = 1'b1;
        #1;
        checks++;
        if ({mif.rd_sel, mif.rd_x, mif.rd_y} !== {1'b1, 4'd6, 4'd1}) begin
            errors++;
            $display("FAIL stall_resume_addr: got sel=%0b (%0d,%0d), expected 1 (6,1)", mif.rd_sel, mif.rd_x, mif.rd_y);
        end
        @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b1, 4'd6, 4'd1, 2'b10}) begin
            errors++;
            $display("FAIL stall_head: got we=%0b (%0d,%0d) d=%b, expected 1 (6,1) 10",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        @(negedge clk);
        checks++;
        if ({mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data} !== {1'b1, 4'd2, 4'd1, 2'b00}) begin
            errors++;
            $display("FAIL stall_tail: got we=%0b (%0d,%0d) d=%b, expected 1 (2,1) 00",
                     mif.mem_we, mif.mem_x, mif.mem_y, mif.mem_data);
        end
        wait_idle("stall", 20);
    endtask

    task automatic test_back_to_back();
        int base, k;
        logic [39:0] got;
        base = wr_n;
        @(negedge clk);
        dir_in    = 2'b01;
        step_tick = 1'b1;
        @(negedge clk);
        dir_in = 2'b11;
        @(negedge clk);
        step_tick = 1'b0;
        repeat (20) @(negedge clk);
        got = '0;
        for (int i = 0; i < 4; i++) begin
            k   = base + i;
            got = {got[29:0], log_x[k[11:0]], log_y[k[11:0]], log_d[k[11:0]]};
        end
        checks++;
        if (wr_n - base !== 4) begin
            errors++;
            $display("FAIL b2b_write_count: got %0d, expected 4", wr_n - base);
        end
        checks++;
        if (got !== {4'd7, 4'd1, 2'b10, 4'd3, 4'd1, 2'b00, 4'd8, 4'd1, 2'b10, 4'd4, 4'd1, 2'b00}) begin
            errors++;
            $display("FAIL b2b_sequence: got %h, expected head(7,1) tail(3,1) head(8,1) tail(4,1)", got);
        end
        checks++;
        if ({busy, length} !== {1'b0, 6'd4}) begin
            errors++;
            $display("FAIL b2b_status: got busy=%0b len=%0d, expected 0 4", busy, length);
        end
    endtask

    task automatic test_wall();
        int base, k;
        for (int i = 0; i < 7; i++) begin
            pulse_tick(2'b01);
            repeat (6) @(negedge clk);
        end
        k = wr_n - 2;
        checks++;
        if ({log_x[k[11:0]], log_y[k[11:0]], log_d[k[11:0]], length} !== {4'd15, 4'd1, 2'b10, 6'd4}) begin
            errors++;
            $display("FAIL wall_approach: got head (%0d,%0d) d=%b len=%0d, expected (15,1) 10 4",
                     log_x[k[11:0]], log_y[k[11:0]], log_d[k[11:0]], length);
        end
        base = wr_n;
        pulse_tick(2'b01);
        repeat (6) @(negedge clk);
`ifdef SNAKE_WRAP_EN
        checks++;
        if ({game_over, log_x[base[11:0]], log_y[base[11:0]], log_d[base[11:0]]} !== {1'b0, 4'd1, 4'd1, 2'b10}) begin
            errors++;
            $display("FAIL wall_wrap: got over=%0b head (%0d,%0d) d=%b, expected 0 (1,1) 10",
                     game_over, log_x[base[11:0]], log_y[base[11:0]], log_d[base[11:0]]);
        end
`else
        checks++;
        if ({game_over, busy} !== 2'b10 || wr_n !== base) begin
            errors++;
            $display("FAIL wall_over: got over=%0b busy=%0b writes=%0d, expected 1 0 0", game_over, busy, wr_n - base);
        end
        pulse_tick(2'b00);
        repeat (6) @(negedge clk);
        checks++;
        if (game_over !== 1'b1 || wr_n !== base) begin
            errors++;
            $display("FAIL over_sticky: got over=%0b writes=%0d, expected 1 0", game_over, wr_n - base);
        end
`endif
    endtask

    task automatic test_start();
        int base, nz;
        base = wr_n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({game_over, busy, length} !== {1'b0, 1'b1, 6'd3}) begin
            errors++;
            $display("FAIL start_status: got over=%0b busy=%0b len=%0d, expected 0 1 3", game_over, busy, length);
        end
        wait_idle("restart", 400);
        repeat (2) @(negedge clk);
        nz = count_nonzero();
        checks++;
        if (wr_n - base !== 229 || nz !== 4 || world[11][4] !== 2'b01 || world[3][1] !== 2'b10) begin
            errors++;
            $display("FAIL start_rebuild: got writes=%0d nonzero=%0d food=%b head=%b, expected 229 4 01 10",
                     wr_n - base, nz, world[11][4], world[3][1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at 2 ms, expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_step();
        test_grow();
        test_stall();
        test_back_to_back();
        test_wall();
        test_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
